// File: rtl/spu_fetch_pkg.sv
// Shared types and constants for the SPU instruction fetch stage.
package spu_fetch_pkg;
    localparam int          PC_W          = 32;
    localparam int          DEF_BUF_DEPTH = 4;
    localparam logic [31:0] NOP_INSTR     = 32'h4020_0000;

    // One fetched instruction pair together with its byte address.
    typedef struct packed {
        logic [PC_W-1:0] addr;
        logic [31:0]     instr1;
        logic [31:0]     instr2;
        logic            slot_kill;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// In-order FIFO of fetched instruction pairs; flush empties it in one cycle.
module fetch_fifo
    import spu_fetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t dout,
    output logic [CW-1:0] occupancy,
    output logic         full,
    output logic         empty
);
    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (occupancy == CW'(DEPTH));
    assign empty   = (occupancy == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            occupancy <= occupancy + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: issues aligned pair requests under a credit limit, buffers
// responses and drives the IF/ID register, honouring stalls and redirects.
module instruction_fetch_unit
    import spu_fetch_pkg::*;
#(
    parameter int                 PCbitsize = PC_W,
    parameter int                 BUF_DEPTH = DEF_BUF_DEPTH,
    parameter logic [PCbitsize-1:0] RESET_PC = '0,
    parameter logic [31:0]        NOP_INSTR = spu_fetch_pkg::NOP_INSTR
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 branch_taken,
    input  logic [PCbitsize-1:0] branch_target,
    output logic                 mem_req,
    output logic [PCbitsize-1:0] mem_addr,
    input  logic                 mem_gnt,
    input  logic                 mem_rvalid,
    input  logic [63:0]          mem_rdata,
    output logic [PCbitsize-1:0] PC_adderOut,
    output logic [31:0]          instruction1,
    output logic [31:0]          instruction2,
    output logic                 fetch_valid
);
    localparam int CW = $clog2(BUF_DEPTH) + 1;

    logic [PCbitsize-1:0] fetch_pc;
    logic [PCbitsize-1:0] resp_pc;
    logic [PCbitsize-1:0] target_aligned;
    logic [CW-1:0]        outstanding;
    logic [CW-1:0]        drop_cnt;
    logic [CW-1:0]        occupancy;
    logic [CW:0]          credit_used;
    logic                 kill_pending;
    logic                 fire;
    logic                 push;
    logic                 pop;
    logic                 full;
    logic                 empty;
    logic                 unused_bits;
    fetch_entry_t         push_entry;
    fetch_entry_t         head;

    assign target_aligned = {branch_target[PCbitsize-1:3], 3'b000};
    assign unused_bits    = ^{branch_target[1:0], full};

    // Buffered plus in-flight pairs may never exceed the FIFO depth.
    assign credit_used = {1'b0, occupancy} + {1'b0, outstanding};
    assign mem_req     = !reset && !branch_taken && (credit_used < (CW+1)'(BUF_DEPTH));
    assign mem_addr    = fetch_pc;
    assign fire        = mem_req && mem_gnt;

    assign push = mem_rvalid && (drop_cnt == '0) && !branch_taken;
    assign pop  = !empty && (!fetch_valid || !stall) && !branch_taken;

    assign push_entry = '{addr:      resp_pc,
                          instr1:    mem_rdata[63:32],
                          instr2:    mem_rdata[31:0],
                          slot_kill: kill_pending};

    fetch_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .flush     (branch_taken),
        .din       (push_entry),
        .dout      (head),
        .occupancy (occupancy),
        .full      (full),
        .empty     (empty)
    );

    // resp_pc tracks the address of the next response that will be kept.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc     <= {RESET_PC[PCbitsize-1:3], 3'b000};
            resp_pc      <= {RESET_PC[PCbitsize-1:3], 3'b000};
            outstanding  <= '0;
            drop_cnt     <= '0;
            kill_pending <= 1'b0;
        end else begin
            outstanding <= outstanding + CW'(fire) - CW'(mem_rvalid);
            if (branch_taken) begin
                fetch_pc     <= target_aligned;
                resp_pc      <= target_aligned;
                drop_cnt     <= outstanding - CW'(mem_rvalid);
                kill_pending <= branch_target[2];
            end else begin
                if (fire) fetch_pc <= fetch_pc + PCbitsize'(8);
                if (mem_rvalid && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
                if (push) begin
                    resp_pc      <= resp_pc + PCbitsize'(8);
                    kill_pending <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_valid  <= 1'b0;
            PC_adderOut  <= '0;
            instruction1 <= NOP_INSTR;
            instruction2 <= NOP_INSTR;
        end else if (branch_taken) begin
            fetch_valid  <= 1'b0;
            instruction1 <= NOP_INSTR;
            instruction2 <= NOP_INSTR;
        end else if (pop) begin
            fetch_valid  <= 1'b1;
            PC_adderOut  <= head.addr + PCbitsize'(8);
            instruction1 <= head.slot_kill ? NOP_INSTR : head.instr1;
            instruction2 <= head.instr2;
        end else if (empty && !stall) begin
            fetch_valid  <= 1'b0;
            instruction1 <= NOP_INSTR;
            instruction2 <= NOP_INSTR;
        end
    end
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Fetch stage feeding the IF/ID pipeline register of the dual-issue SPU core. It drives a fetch PC and requests one aligned 64-bit instruction pair per cycle from local store. Returned pairs are buffered in a small in-order FIFO. The unit presents instruction1, instruction2 and PC+8 to IF/ID, honouring decode stalls and branch redirects.

Parameters:
PCbitsize, 32, width of PC and local-store byte address
BUF_DEPTH, 4, instruction-pair FIFO entries (power of 2, >=2)
RESET_PC, 0, fetch address after reset
NOP_INSTR, 32'h4020_0000, SPU nop; used for bubbles and misaligned branch slot

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
stall  in  1  decode cannot accept; hold outputs
branch_taken  in  1  redirect fetch; flush younger instructions
branch_target  in  PCbitsize  byte address of redirect target
mem_req  out  1  fetch request valid
mem_addr  out  PCbitsize  8-byte-aligned request address
mem_gnt  in  1  request accepted this cycle
mem_rvalid  in  1  response valid; in order, latency >=1
mem_rdata  in  64  instruction pair, big-endian
PC_adderOut  out  PCbitsize  address of pair + 8
instruction1  out  32  word at pair address
instruction2  out  32  word at pair address + 4
fetch_valid  out  1  outputs hold a real pair

Behaviour:
- Clocking and reset: single clk domain. reset is synchronous and active-high; it wins over every other input.
- Reset values: fetch_pc=RESET_PC with [2:0] zeroed; mem_req=0; FIFO empty; outstanding=0; drop_cnt=0; fetch_valid=0; PC_adderOut=0; instruction1=instruction2=NOP_INSTR.
- The memory is reset by the same reset, so no stale responses arrive after reset.
- Request issue: mem_req=1 when !reset, !branch_taken and (occupancy + outstanding) < BUF_DEPTH.
- mem_addr=fetch_pc. Request fires on mem_req&&mem_gnt; fetch_pc then advances by 8 (wraps modulo 2^PCbitsize). mem_addr is held stable while mem_gnt=0.
- outstanding is incremented on fire and decremented on mem_rvalid. Both in one cycle leave it unchanged.
- Response: instruction1=mem_rdata[63:32], instruction2=mem_rdata[31:0].
- When drop_cnt=0, the pair, its address and a slot-kill bit are pushed into the FIFO. When drop_cnt>0, the response is discarded and drop_cnt is decremented.
- Output register:
  - Loads from the FIFO head (pop) when FIFO is non-empty and (!fetch_valid or !stall).
  - If empty and not stalled, fetch_valid goes to 0, instructions drive NOP_INSTR, and PC_adderOut holds.
  - PC_adderOut = entry address + 8.
- Latency: mem_rvalid in cycle N means FIFO entry at end of N, output load at end of N+1, fetch_valid=1 in N+2.
- Stall: all outputs are held bit-stable and the FIFO keeps filling until the credit limit.
- Branch (branch_taken=1):
  - FIFO is cleared and fetch_valid=0 next cycle; outputs go to NOP_INSTR.
  - drop_cnt <= outstanding - mem_rvalid. The same-cycle response is discarded.
  - fetch_pc <= {branch_target[PCbitsize-1:3],3'b000}. No request is issued in the branch cycle.
  - New requests are allowed while drop_cnt>0.
  - branch_target[2]=1: the first fetched pair gets slot-kill, so instruction1 is output as NOP_INSTR.
  - branch_target[1:0] is ignored.
- Simultaneous branch and stall: branch wins. Simultaneous branch and reset: reset wins.
- FIFO full: push never overflows, by the credit rule. FIFO empty plus pop request: no pop; bubble behaviour applies.

Decomposition:
- Shared package spu_fetch_pkg:
  - NOP_INSTR constant.
  - fetch_entry_t struct: addr, instr1, instr2, slot_kill.
  - Depth/width constants.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t, BUF_DEPTH deep, with push, pop, flush, occupancy, full and empty.
- The top level holds the PC, credit/drop counters and output register.

Test Plan:
1. Startup: reset for 2 cycles, RESET_PC=0, memory latency 1, gnt=1, LS[0]=0x11111111, LS[4]=0x22222222 -> first fetch_valid=1 shows PC_adderOut=0x8, instruction1=0x11111111, instruction2=0x22222222. Subsequent PC_adderOut values are 0x10, 0x18, ...
2. Stall: assert stall for 6 cycles mid-stream -> outputs bit-stable; mem_req drops once occupancy+outstanding=4. On release, pairs resume with no gap or duplicate.
3. Branch with in-flight responses: memory latency 3, branch_taken with target 0x100 while 2 requests are outstanding -> both responses discarded. Next valid output is PC_adderOut=0x108 with LS[0x100]/LS[0x104].
4. Misaligned target: branch to 0x104 -> first valid output is PC_adderOut=0x108, instruction1=0x40200000, instruction2=LS[0x104]. The following output is PC_adderOut=0x110 with no kill.
5. Grant backpressure: mem_gnt=0 for 3 cycles -> mem_addr constant, fetch_pc not advanced. Addresses resume sequentially.
6. Reset mid-run with FIFO full, stall=1 -> next cycle fetch_valid=0, instructions=NOP_INSTR, PC_adderOut=0. After release, fetch restarts at RESET_PC.
